strided_fifo_feeder: RTL and testbench
======================================

STRIDED_FIFO_FEEDER -- requirements
Module: strided_fifo_feeder

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- WIDTH, 16, data word width.
- ADDR_WIDTH, 16, buffer address width.
- NUM_CH, 4, number of destination FIFOs, at least 1.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, single clock, rising edge.
- rstn, in, 1, asynchronous active-low reset.
- start, in, 1, one-cycle pulse that launches a transfer (sampled in IDLE only).
- abort, in, 1, cancels the transfer.
- loop, in, 1, repeat mode (sampled with start).
- base_addr, in, ADDR_WIDTH, first address.
- addr_step, in, ADDR_WIDTH, address stride (0 is treated as 1).
- end_addr, in, ADDR_WIDTH, last permitted address (inclusive).
- mem_cs, out, 1, buffer read strobe.
- mem_addr, out, ADDR_WIDTH, buffer read address.
- from_mem, in, WIDTH, buffer read data, valid exactly 1 cycle after mem_cs.
- full, in, NUM_CH, per-channel FIFO full flags.
- w_en, out, NUM_CH, per-channel one-hot write strobe.
- to_fifo, out, WIDTH, write data shared by all channels.
- busy, out, 1, high while not in IDLE.
- done, out, 1, one-cycle completion pulse.

Function
REQ-003 The FSM SHALL be one-hot with states IDLE, LOAD, DRAIN, FINISH.
REQ-004 IDLE->LOAD SHALL occur on start when base_addr<=end_addr; if base_addr>end_addr, IDLE->FINISH.
REQ-005 start, base_addr, addr_step, end_addr and loop SHALL be latched on the start cycle; start outside IDLE SHALL be ignored.
REQ-006 Word k SHALL be read from base_addr + k*step and routed to channel k mod NUM_CH; the channel index SHALL restart at 0 on every pass.
REQ-007 Reads SHALL issue only in LOAD, one per cycle at most, and only when (skid occupancy + reads in flight - pop this cycle) < 2.
REQ-008 Read data SHALL enter a 2-entry skid buffer the cycle after mem_cs; each entry carries its channel tag.
REQ-009 The head entry SHALL pop with to_fifo = data and w_en[tag] = 1 in a cycle where full[tag] = 0; w_en SHALL be all-zero otherwise.
REQ-010 Data SHALL never be written into a channel whose full bit is high, and no word SHALL be lost or reordered.
REQ-011 Next address SHALL be computed at ADDR_WIDTH+1 bits. If the sum exceeds end_addr or carries out:
- loop=0: the current read is the last; LOAD->DRAIN.
- loop=1: the next address is the latched base_addr.
REQ-012 In steady state with full all-low, the block SHALL sustain 1 word/cycle; the first w_en SHALL occur 2 cycles after the first mem_cs.
REQ-013 DRAIN->FINISH SHALL occur when the skid buffer is empty and no read is in flight.
REQ-014 FINISH SHALL assert done for 1 cycle, then go to IDLE.
REQ-015 abort in any non-IDLE state SHALL go to IDLE next cycle, flush the skid buffer and in-flight data (no w_en after the abort cycle), and not assert done.
REQ-016 If abort and start coincide in IDLE, abort SHALL win.
REQ-017 A full transition mid-stream SHALL stall only the head entry; reads continue until the REQ-007 limit is reached.

Reset
REQ-018 On rstn low, the block SHALL asynchronously enter IDLE, empty the skid buffer, clear in-flight tracking, and zero mem_cs, mem_addr, w_en, to_fifo, busy and done.
REQ-019 Reset deassertion mid-transfer SHALL resume in IDLE, with no writes until a new start.

Verification
REQ-020 The bench SHALL cover these scenarios:
- base=0, step=1, end=7, NUM_CH=4, full=0 -> 8 writes on consecutive cycles, channels 0,1,2,3,0,1,2,3, data=mem[0..7], done 1 cycle after the last w_en drains.
- base=2, step=3, end=10 -> addresses 2,5,8 only; base=5, end=3 -> done with no mem_cs.
- full[1] held high for 5 cycles during the stream -> at most 2 words buffered, no w_en[1] while full, order preserved.
- base=0xFFF0, step=0x20, end=0xFFFF (16-bit) -> a single read at 0xFFF0; carry terminates the transfer.
- loop=1, base=0, step=1, end=2, abort after 7 reads -> address sequence 0,1,2,0,1,2,0; no w_en after the abort cycle; done never asserts.
- rstn pulsed low mid-LOAD -> all outputs zero immediately; start ignored until rstn returns high.

Source files
------------

// File: rtl/strided_fifo_feeder.sv
// Strided buffer reader that deals words round-robin into NUM_CH FIFOs.
// A 2-entry tagged skid buffer absorbs the 1-cycle read latency and per-channel back-pressure.
module strided_fifo_feeder #(
   parameter int WIDTH      = 16,
   parameter int ADDR_WIDTH = 16,
   parameter int NUM_CH     = 4
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  start,
   input  logic                  abort,
   input  logic                  loop,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH-1:0] addr_step,
   input  logic [ADDR_WIDTH-1:0] end_addr,
   output logic                  mem_cs,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [WIDTH-1:0]      from_mem,
   input  logic [NUM_CH-1:0]     full,
   output logic [NUM_CH-1:0]     w_en,
   output logic [WIDTH-1:0]      to_fifo,
   output logic                  busy,
   output logic                  done
);

   localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [CW-1:0] CH_LAST = CW'(NUM_CH - 1);

   typedef enum logic [3:0] {
      S_IDLE   = 4'b0001,
      S_LOAD   = 4'b0010,
      S_DRAIN  = 4'b0100,
      S_FINISH = 4'b1000
   } state_t;

   state_t                r_state, w_next;
   logic [ADDR_WIDTH-1:0] r_base, r_step, r_end, r_addr;
   logic                  r_loop;
   logic [CW-1:0]         r_ch;
   logic                  r_if_vld;
   logic [CW-1:0]         r_if_tag;
   logic [WIDTH-1:0]      r_data [2];
   logic [CW-1:0]         r_tag  [2];
   logic [1:0]            r_cnt;

   logic                  w_pop, w_issue, w_wrap, w_drained, w_wr_idx, w_launch;
   logic [2:0]            w_occ;
   logic [ADDR_WIDTH:0]   w_sum;

   // Occupancy counts words already buffered plus the read whose data lands this cycle.
   assign w_pop     = (r_cnt != 2'd0) && !full[r_tag[0]];
   assign w_occ     = {1'b0, r_cnt} + {2'b0, r_if_vld} - {2'b0, w_pop};
   assign w_issue   = (r_state == S_LOAD) && !abort && (w_occ < 3'd2);
   assign w_sum     = {1'b0, r_addr} + {1'b0, r_step};
   assign w_wrap    = w_sum[ADDR_WIDTH] || (w_sum[ADDR_WIDTH-1:0] > r_end);
   assign w_drained = (r_cnt == {1'b0, w_pop}) && !r_if_vld;
   assign w_wr_idx  = (r_cnt == 2'd1) && !w_pop;
   assign w_launch  = (r_state == S_IDLE) && start && !abort;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (w_launch) w_next = (base_addr <= end_addr) ? S_LOAD : S_FINISH;
         S_LOAD:   if (abort) w_next = S_IDLE;
                   else if (w_issue && w_wrap && !r_loop) w_next = S_DRAIN;
         S_DRAIN:  if (abort) w_next = S_IDLE;
                   else if (w_drained) w_next = S_FINISH;
         S_FINISH: w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_en    = '0;
      to_fifo = '0;
      if (w_pop) begin
         w_en[r_tag[0]] = 1'b1;
         to_fifo        = r_data[0];
      end
   end

   assign mem_cs   = w_issue;
   assign mem_addr = r_addr;
   assign busy     = (r_state != S_IDLE);
   assign done     = (r_state == S_FINISH) && !abort;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_base   <= '0;
         r_step   <= '0;
         r_end    <= '0;
         r_addr   <= '0;
         r_loop   <= 1'b0;
         r_ch     <= '0;
         r_if_vld <= 1'b0;
         r_if_tag <= '0;
         r_data   <= '{default: '0};
         r_tag    <= '{default: '0};
         r_cnt    <= 2'd0;
      end else begin
         if (w_launch) begin
            r_base <= base_addr;
            r_step <= (addr_step == '0) ? ADDR_WIDTH'(1) : addr_step;
            r_end  <= end_addr;
            r_loop <= loop;
            r_addr <= base_addr;
            r_ch   <= '0;
         end
         // On wrap the channel restarts at 0 so every pass maps identically.
         if (w_issue) begin
            r_if_tag <= r_ch;
            if (w_wrap) begin
               r_addr <= r_base;
               r_ch   <= '0;
            end else begin
               r_addr <= w_sum[ADDR_WIDTH-1:0];
               r_ch   <= (r_ch == CH_LAST) ? '0 : r_ch + 1'b1;
            end
         end
         if (abort && (r_state != S_IDLE)) begin
            r_if_vld <= 1'b0;
            r_cnt    <= 2'd0;
         end else begin
            r_if_vld <= w_issue;
            if (w_pop) begin
               r_data[0] <= r_data[1];
               r_tag[0]  <= r_tag[1];
            end
            if (r_if_vld) begin
               r_data[w_wr_idx] <= from_mem;
               r_tag[w_wr_idx]  <= r_if_tag;
            end
            r_cnt <= r_cnt + {1'b0, r_if_vld} - {1'b0, w_pop};
         end
      end
   end

endmodule

// File: tb/tb_strided_fifo_feeder.sv
// Directed bench for strided_fifo_feeder: table of transfers plus stall, abort and reset sequences.
module tb_strided_fifo_feeder;

   localparam int W   = 16;
   localparam int AW  = 16;
   localparam int NCH = 4;

   logic           clk = 1'b0, rstn = 1'b0, start = 1'b0, abort = 1'b0, loop = 1'b0;
   logic [AW-1:0]  base_addr = '0, addr_step = '0, end_addr = '0;
   logic           mem_cs;
   logic [AW-1:0]  mem_addr;
   logic [W-1:0]   from_mem = '0;
   logic [NCH-1:0] full = '0;
   logic [NCH-1:0] w_en;
   logic [W-1:0]   to_fifo;
   logic           busy, done;

   strided_fifo_feeder #(.WIDTH(W), .ADDR_WIDTH(AW), .NUM_CH(NCH)) dut (
      .clk(clk), .rstn(rstn), .start(start), .abort(abort), .loop(loop),
      .base_addr(base_addr), .addr_step(addr_step), .end_addr(end_addr),
      .mem_cs(mem_cs), .mem_addr(mem_addr), .from_mem(from_mem), .full(full),
      .w_en(w_en), .to_fifo(to_fifo), .busy(busy), .done(done)
   );

   // ---------------- clock / reset / buffer model ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [W-1:0] memf(input logic [AW-1:0] a);
      return {a[7:0] ^ 8'h5A, ~a[7:0]} ^ {a[15:8], 8'h00};
   endfunction

   always @(posedge clk) if (mem_cs) from_mem <= memf(mem_addr);

   // ---------------- monitor ----------------
   logic [AW-1:0]    rd_q[$];
   int               rd_cyc_q[$];
   logic [NCH+W-1:0] wr_q[$];
   int               wr_cyc_q[$];
   logic [NCH+W-1:0] exp_q[$];
   int done_cnt, done_cyc, full_viol, onehot_viol, max_occ;

   always @(negedge clk) begin
      if (mem_cs) begin
         rd_q.push_back(mem_addr);
         rd_cyc_q.push_back(cyc);
      end
      if (w_en != '0) begin
         wr_q.push_back({w_en, to_fifo});
         wr_cyc_q.push_back(cyc);
         if ((w_en & full) != '0) full_viol++;
         if (!$onehot(w_en)) onehot_viol++;
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (rd_q.size() - wr_q.size() > max_occ) max_occ = rd_q.size() - wr_q.size();
   end

   // ---------------- scoreboard helpers ----------------
   int pass_cnt = 0, total_cnt = 0;
   int start_cyc, abort_cyc;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
   endtask

   function automatic logic [NCH+W-1:0] exp_word(input int ch, input logic [AW-1:0] a);
      logic [NCH-1:0] oh;
      oh = NCH'(1) << ch;
      return {oh, memf(a)};
   endfunction

   task automatic clear_log();
      rd_q.delete(); rd_cyc_q.delete(); wr_q.delete(); wr_cyc_q.delete(); exp_q.delete();
      done_cnt = 0; done_cyc = -1; full_viol = 0; onehot_viol = 0; max_occ = 0;
   endtask

   task automatic pulse_start(input logic [AW-1:0] b, input logic [AW-1:0] s,
                              input logic [AW-1:0] e, input logic l);
      @(posedge clk); #1;
      base_addr = b; addr_step = s; end_addr = e; loop = l; start = 1'b1;
      start_cyc = cyc;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk); #1;
         if (done_cnt > 0) ok = 1'b1;
      end
      check({name, "_done_seen"}, 32'(ok), 32'd1);
   endtask

   task automatic score(input string name, input bit prefix_only);
      if (!prefix_only) check({name, "_nwrites"}, 32'(wr_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
         check({name, "_word"}, 32'(wr_q[i]), 32'(exp_q[i]));
      check({name, "_no_write_while_full"}, 32'(full_viol), 32'd0);
      check({name, "_onehot"}, 32'(onehot_viol), 32'd0);
   endtask

   task automatic check_idle_outputs(input string name);
      check({name, "_mem_cs"},  32'(mem_cs),   32'd0);
      check({name, "_mem_addr"}, 32'(mem_addr), 32'd0);
      check({name, "_w_en"},    32'(w_en),     32'd0);
      check({name, "_to_fifo"}, 32'(to_fifo),  32'd0);
      check({name, "_busy"},    32'(busy),     32'd0);
      check({name, "_done"},    32'(done),     32'd0);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [AW-1:0] base;
      logic [AW-1:0] step;
      logic [AW-1:0] endv;
      logic [AW-1:0] eff_step;
      int            n_exp;
   } vec_t;

   vec_t vecs[6];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{16'h0000, 16'h0001, 16'h0007, 16'h0001, 8};
      vecs[1] = '{16'h0002, 16'h0003, 16'h000A, 16'h0003, 3};
      vecs[2] = '{16'h0005, 16'h0001, 16'h0003, 16'h0001, 0};
      vecs[3] = '{16'hFFF0, 16'h0020, 16'hFFFF, 16'h0020, 1};
      vecs[4] = '{16'h0004, 16'h0000, 16'h0006, 16'h0001, 3};
      vecs[5] = '{16'h0007, 16'h0007, 16'h0007, 16'h0007, 1};
      clear_log();

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check_idle_outputs("reset");
      rstn = 1'b1;

      foreach (vecs[v]) begin
         logic [AW-1:0] a;
         clear_log();
         pulse_start(vecs[v].base, vecs[v].step, vecs[v].endv, 1'b0);
         wait_done($sformatf("vec%0d", v), 100);
         repeat (3) @(posedge clk);
         #1;
         check($sformatf("vec%0d_nreads", v), 32'(rd_q.size()), 32'(vecs[v].n_exp));
         for (int k = 0; k < vecs[v].n_exp; k++) begin
            a = vecs[v].base + AW'(k) * vecs[v].eff_step;
            if (k < rd_q.size()) check($sformatf("vec%0d_addr%0d", v, k), 32'(rd_q[k]), 32'(a));
            exp_q.push_back(exp_word(k % NCH, a));
         end
         score($sformatf("vec%0d", v), 1'b0);
         check($sformatf("vec%0d_done_count", v), 32'(done_cnt), 32'd1);
         if (vecs[v].n_exp > 0 && wr_q.size() > 0 && rd_q.size() > 0) begin
            check($sformatf("vec%0d_first_latency", v), 32'(wr_cyc_q[0] - rd_cyc_q[0]), 32'd2);
            check($sformatf("vec%0d_back_to_back", v),
                  32'(wr_cyc_q[wr_cyc_q.size()-1] - wr_cyc_q[0]), 32'(vecs[v].n_exp - 1));
            check($sformatf("vec%0d_done_after_last", v),
                  32'(done_cyc), 32'(wr_cyc_q[wr_cyc_q.size()-1] + 1));
         end else if (vecs[v].n_exp == 0) begin
            check($sformatf("vec%0d_done_cycle", v), 32'(done_cyc), 32'(start_cyc + 1));
         end
      end

      // full[1] stall for 5 cycles in the middle of a 16-word stream
      begin
         bit seen;
         clear_log();
         pulse_start(16'h0000, 16'h0001, 16'h000F, 1'b0);
         seen = 1'b0;
         for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk); #1;
            if (wr_q.size() >= 1) seen = 1'b1;
         end
         check("stall_first_write", 32'(seen), 32'd1);
         @(posedge clk); #1;
         full = 4'b0010;
         repeat (5) @(posedge clk);
         #1;
         full = 4'b0000;
         wait_done("stall", 100);
         for (int k = 0; k < 16; k++) exp_q.push_back(exp_word(k % NCH, AW'(k)));
         score("stall", 1'b0);
         check("stall_max_outstanding", 32'(max_occ <= 2), 32'd1);
         if (wr_cyc_q.size() > 0)
            check("stall_span", 32'(wr_cyc_q[wr_cyc_q.size()-1] - wr_cyc_q[0]), 32'd20);
      end

      // loop mode with abort after 7 reads
      begin
         logic [AW-1:0] exp_addr [7];
         int late;
         bit seen;
         exp_addr = '{16'd0, 16'd1, 16'd2, 16'd0, 16'd1, 16'd2, 16'd0};
         clear_log();
         pulse_start(16'h0000, 16'h0001, 16'h0002, 1'b1);
         seen = 1'b0;
         for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk); #1;
            if (rd_q.size() >= 7) seen = 1'b1;
         end
         check("loop_reached_7_reads", 32'(seen), 32'd1);
         @(posedge clk); #1;
         abort = 1'b1;
         abort_cyc = cyc;
         @(posedge clk); #1;
         abort = 1'b0;
         loop  = 1'b0;
         repeat (6) @(posedge clk);
         #1;
         check("loop_nreads", 32'(rd_q.size()), 32'd7);
         for (int k = 0; k < 7; k++) begin
            if (k < rd_q.size()) check($sformatf("loop_addr%0d", k), 32'(rd_q[k]), 32'(exp_addr[k]));
            exp_q.push_back(exp_word(k % 3, exp_addr[k]));
         end
         score("loop", 1'b1);
         check("loop_min_writes", 32'(wr_q.size() >= 5), 32'd1);
         late = 0;
         foreach (wr_cyc_q[j]) if (wr_cyc_q[j] > abort_cyc) late++;
         check("loop_no_write_after_abort", 32'(late), 32'd0);
         check("loop_no_done", 32'(done_cnt), 32'd0);
         check("loop_idle_after_abort", 32'(busy), 32'd0);
      end

      // start and abort together in IDLE: abort wins
      clear_log();
      @(posedge clk); #1;
      base_addr = 16'h0000; addr_step = 16'h0001; end_addr = 16'h0007;
      start = 1'b1; abort = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("start_abort_busy", 32'(busy), 32'd0);
      check("start_abort_nreads", 32'(rd_q.size()), 32'd0);
      check("start_abort_done", 32'(done_cnt), 32'd0);

      // reset pulsed mid-LOAD; start while in reset must be ignored
      clear_log();
      pulse_start(16'h0000, 16'h0001, 16'h003F, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      check("midload_busy_before_reset", 32'(busy), 32'd1);
      rstn = 1'b0;
      #1;
      check_idle_outputs("async_reset");
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      clear_log();
      @(posedge clk); #1;
      rstn = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("post_reset_busy", 32'(busy), 32'd0);
      check("post_reset_nreads", 32'(rd_q.size()), 32'd0);
      check("post_reset_nwrites", 32'(wr_q.size()), 32'd0);

      // recovery transfer after reset
      clear_log();
      pulse_start(16'h0010, 16'h0001, 16'h0013, 1'b0);
      wait_done("recover", 100);
      for (int k = 0; k < 4; k++) exp_q.push_back(exp_word(k, AW'(16 + k)));
      score("recover", 1'b0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
